obi_arbiter_2to1: RTL
=====================

Name: obi_arbiter_2to1

Overview:
- Two-master to one-slave OBI arbiter that sits directly upstream of one port of the dual-port SRAM, for example port 1, the read/write port.
- Lets two requesters share one SRAM port, such as the core LSU and a DMA/host loader.
- Arbitrates requests round-robin.
- Tracks outstanding transactions in an ID FIFO, so each rvalid/rdata is routed back to the master that issued it.
- The request path is combinational, so the arbiter adds no cycle of latency.

Parameters:
- MAX_OUTSTANDING, 2: depth of the ID FIFO, i.e. the maximum number of granted transactions still waiting for rvalid. Must be a power of two and at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_m0  obi_req_if.slave  -  master 0 request: req, we, be[3:0], addr[31:0], wdata[31:0], gnt.
- rsp_m0  obi_rsp_if.master  -  master 0 response: rvalid, rdata[31:0].
- req_m1  obi_req_if.slave  -  master 1 request (same fields as master 0).
- rsp_m1  obi_rsp_if.master  -  master 1 response (same fields as master 0).
- req_s  obi_req_if.master  -  request to the SRAM port.
- rsp_s  obi_rsp_if.slave  -  response from the SRAM port.
- perf_gnt_m0_o  out  32  grant count for master 0 (see Optional Feature).
- perf_gnt_m1_o  out  32  grant count for master 1.
- perf_stall_o  out  32  count of cycles spent stalled on a conflict or on a full FIFO.

Behaviour:
- Reset (clk_i edge with rst_i=1):
  - FIFO emptied.
  - Round-robin pointer set to m0.
  - Lock cleared.
  - Perf counters cleared.
  - With req_m0.req=req_m1.req=0, every output is 0: req_s.req, req_m*.gnt, rsp_m*.rvalid, rsp_m*.rdata.
- Reset in the middle of a transaction discards all outstanding IDs. Any rvalid arriving afterwards with an empty FIFO is dropped.
- Winner selection, evaluated every cycle:
  - If the lock is set, the locked master wins.
  - Otherwise, if only one master requests, that master wins.
  - If both request, the master at the round-robin pointer wins.
- Forwarding:
  - req_s.req = winner.req AND NOT fifo_full.
  - req_s.we/be/addr/wdata are muxed from the winner.
  - The winner sees gnt = req_s.gnt AND req_s.req. The loser sees gnt = 0.
- Lock:
  - Set when req_s.req=1 and req_s.gnt=0.
  - Cleared on grant.
  - Purpose: a request the slave has not yet granted is never switched to the other master, which OBI address/attribute stability requires.
- Pointer update: on a handshake (req_s.req AND req_s.gnt), the pointer moves to the master that did not win.
- ID FIFO:
  - Handshake pushes the winner's ID (1 bit).
  - rsp_s.rvalid pops the head entry.
  - rsp_s.rvalid and rdata go to the master named by the head entry; the other master gets rvalid=0, rdata=0.
  - Push and pop in the same cycle are both allowed; occupancy is unchanged, including when the FIFO is full.
  - While full with no pop that cycle, req_s.req is held at 0 and no gnt is issued.
  - Full is decided on registered occupancy. A pop in the current cycle does not unblock a request until the next cycle.
- Empty-FIFO rvalid: the response is dropped (not routed to either master) and the pointer is not underflowed. A simulation assertion fires.
- Latency:
  - Request to gnt: same cycle as the slave's gnt.
  - rvalid to master: same cycle as the slave's rvalid.
- Throughput: with the SRAM FSM (IDLE→READ/WRITE→IDLE), a handshake can occur at most every second cycle.

Optional Feature:
- Macro: OBI_ARB_PERF_CNT_EN.
- When defined:
  - perf_gnt_m0_o / perf_gnt_m1_o increment on each handshake won by that master.
  - perf_stall_o increments every cycle in which (both masters request) OR (some master requests AND the FIFO is full).
  - All three counters are 32-bit, wrap at 2^32, and reset to 0.
- When undefined: no counter registers exist, and the three outputs are tied to 0.

Decomposition:
- Package obi_arb_pkg holds:
  - typedef master_id_t (logic [0:0]).
  - Constants MST_0 = 1'b0 and MST_1 = 1'b1.
  - typedef perf_cnt_t (logic [31:0]).
- Sub-module obi_arb_id_fifo:
  - Parameterised synchronous FIFO, DEPTH = MAX_OUTSTANDING, element type master_id_t.
  - Ports: push, pop, din, dout, full, empty.
  - Behaviour: same-cycle push+pop allowed, synchronous active-high reset.
- The arbiter top keeps the round-robin pointer, the lock, the muxing and the perf counters.

Test Plan:
- m0 reads addr 0x10 alone, SRAM holding 0xDEADBEEF → m0 gnt in cycle 0; m0 rvalid with rdata=0xDEADBEEF in cycle 1; m1 rvalid stays 0.
- m0 and m1 request together from reset, m0 writes 0x11223344, m1 reads the same address → m0 granted first (pointer at reset); m1 granted at the next handshake and receives 0x11223344; perf_gnt_m0_o=1 and perf_gnt_m1_o=1 (macro on).
- Both masters request continuously for 8 handshakes → grants alternate m0,m1,m0,…; each master gets 4.
- Slave gnt held at 0 for 3 cycles while m0 is pending, m1 raising req in cycle 1 → req_s fields stay on m0's values throughout; m0 granted when gnt rises; m1 granted next.
- MAX_OUTSTANDING=1, slave rvalid delayed → second request blocked (req_s.req=0) until the cycle after rvalid; perf_stall_o counts the blocked cycles.
- Assert rst_i with one transaction outstanding, then inject rvalid → no master sees rvalid; FIFO empty; next grant goes to m0.

Source files
------------

// File: rtl/obi_arbiter_2to1_pkg.sv
// Shared types and constants for the 2:1 OBI arbiter and its ID FIFO.
package obi_arb_pkg;

   typedef logic [0:0]  master_id_t;
   typedef logic [31:0] perf_cnt_t;

   localparam master_id_t MST_0 = 1'b0;
   localparam master_id_t MST_1 = 1'b1;

endpackage

// File: rtl/obi_arbiter_2to1_if.sv
// OBI request channel (req/attributes/gnt) and response channel (rvalid/rdata).
interface obi_req_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;

   modport master (output req, we, be, addr, wdata, input gnt);
   modport slave  (input req, we, be, addr, wdata, output gnt);
endinterface

interface obi_rsp_if;
   logic        rvalid;
   logic [31:0] rdata;

   // master drives the response, slave consumes it
   modport master (output rvalid, rdata);
   modport slave  (input rvalid, rdata);
endinterface

// File: rtl/obi_arbiter_2to1_id_fifo.sv
// Synchronous FIFO of master IDs for outstanding transactions; same-cycle push+pop allowed.
module obi_arb_id_fifo
   import obi_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       i_push,
   input  logic       i_pop,
   input  master_id_t i_din,
   output master_id_t o_dout,
   output logic       o_full,
   output logic       o_empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   master_id_t    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_dout  = r_mem[r_rptr];

   // A push into a full FIFO is only legal when the head leaves in the same cycle
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_din;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + CW'(1);
         end else if (!w_push && w_pop) begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

endmodule

// File: rtl/obi_arbiter_2to1.sv
// Round-robin 2:1 OBI arbiter with in-order response routing via an ID FIFO.
// Define OBI_ARB_PERF_CNT_EN to build the grant/stall performance counters.
module obi_arbiter_2to1
   import obi_arb_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic      clk_i,
   input  logic      rst_i,
   obi_req_if.slave  req_m0,
   obi_rsp_if.master rsp_m0,
   obi_req_if.slave  req_m1,
   obi_rsp_if.master rsp_m1,
   obi_req_if.master req_s,
   obi_rsp_if.slave  rsp_s,
   output perf_cnt_t perf_gnt_m0_o,
   output perf_cnt_t perf_gnt_m1_o,
   output perf_cnt_t perf_stall_o
);

   master_id_t r_rr_ptr;
   master_id_t r_lock_id;
   logic       r_lock;

   master_id_t w_winner;
   master_id_t w_fifo_dout;
   logic       w_win_req;
   logic       w_req_s;
   logic       w_hs;
   logic       w_fifo_full;
   logic       w_fifo_empty;
   logic       w_rsp_valid;
   logic       w_rv_m0;
   logic       w_rv_m1;

   always_comb begin
      w_winner = r_rr_ptr;
      if (r_lock) begin
         w_winner = r_lock_id;
      end else if (req_m0.req && !req_m1.req) begin
         w_winner = MST_0;
      end else if (req_m1.req && !req_m0.req) begin
         w_winner = MST_1;
      end
   end

   assign w_win_req = (w_winner == MST_0) ? req_m0.req : req_m1.req;
   assign w_req_s   = w_win_req & ~w_fifo_full;
   assign w_hs      = w_req_s & req_s.gnt;

   assign req_s.req   = w_req_s;
   assign req_s.we    = (w_winner == MST_0) ? req_m0.we    : req_m1.we;
   assign req_s.be    = (w_winner == MST_0) ? req_m0.be    : req_m1.be;
   assign req_s.addr  = (w_winner == MST_0) ? req_m0.addr  : req_m1.addr;
   assign req_s.wdata = (w_winner == MST_0) ? req_m0.wdata : req_m1.wdata;

   assign req_m0.gnt = w_hs & (w_winner == MST_0);
   assign req_m1.gnt = w_hs & (w_winner == MST_1);

   // Lock keeps an offered-but-ungranted request on the bus so its attributes stay stable
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rr_ptr  <= MST_0;
         r_lock    <= 1'b0;
         r_lock_id <= MST_0;
      end else begin
         r_lock    <= w_req_s & ~req_s.gnt;
         r_lock_id <= w_winner;
         if (w_hs) begin
            r_rr_ptr <= ~w_winner;
         end
      end
   end

   obi_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_push  (w_hs),
      .i_pop   (rsp_s.rvalid),
      .i_din   (w_winner),
      .o_dout  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign w_rsp_valid  = rsp_s.rvalid & ~w_fifo_empty;
   assign w_rv_m0      = w_rsp_valid & (w_fifo_dout == MST_0);
   assign w_rv_m1      = w_rsp_valid & (w_fifo_dout == MST_1);
   assign rsp_m0.rvalid = w_rv_m0;
   assign rsp_m1.rvalid = w_rv_m1;
   assign rsp_m0.rdata  = w_rv_m0 ? rsp_s.rdata : '0;
   assign rsp_m1.rdata  = w_rv_m1 ? rsp_s.rdata : '0;

   always_ff @(posedge clk_i) begin
      assert (rst_i || !(rsp_s.rvalid && w_fifo_empty))
         else $warning("obi_arbiter_2to1: rvalid with no outstanding transaction dropped");
   end

`ifdef OBI_ARB_PERF_CNT_EN
   perf_cnt_t r_perf_gnt_m0;
   perf_cnt_t r_perf_gnt_m1;
   perf_cnt_t r_perf_stall;
   logic      w_stall;

   assign w_stall = (req_m0.req & req_m1.req) | ((req_m0.req | req_m1.req) & w_fifo_full);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_perf_gnt_m0 <= '0;
         r_perf_gnt_m1 <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (w_hs && (w_winner == MST_0)) begin
            r_perf_gnt_m0 <= r_perf_gnt_m0 + 32'd1;
         end
         if (w_hs && (w_winner == MST_1)) begin
            r_perf_gnt_m1 <= r_perf_gnt_m1 + 32'd1;
         end
         if (w_stall) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_gnt_m0_o = r_perf_gnt_m0;
   assign perf_gnt_m1_o = r_perf_gnt_m1;
   assign perf_stall_o  = r_perf_stall;
`else
   assign perf_gnt_m0_o = '0;
   assign perf_gnt_m1_o = '0;
   assign perf_stall_o  = '0;
`endif

endmodule
